// File: rtl/mult_div_pkg.sv
// Shared opcodes, FSM state type and helpers for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_ITER  = 2'd1,
    MD_FINAL = 2'd2
  } md_state_e;

  // Iteration down-counter start value: 32 steps, terminal count at zero.
  localparam logic [4:0] MD_LAST_CNT = 5'd31;

  // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// state    | meaning
// IDLE     | waiting for an issue; MTHI/MTLO complete here in one edge
// ITER     | one shift-add / shift-subtract step per cycle, 32 steps
// FINAL    | sign fix-up and HI/LO load, then back to IDLE
module mult_div
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic [2:0]  md_opcode,
  input  logic [31:0] md_op_x,
  input  logic [31:0] md_op_y,
  input  logic        md_kill,
  output logic        md_busy,
  output logic        md_done,
  output logic        md_div_zero,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] shreg_q;
  logic [31:0] opnd_q;
  logic        is_div_q, neg_res_q, neg_rem_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q, dz_q;

  logic        accept, op_mul, op_div, op_signed, dz_issue;
  logic [31:0] x_mag, y_mag;
  logic [32:0] add_a, add_b;
  logic [33:0] add_res;
  logic        no_borrow;
  logic [63:0] iter_next, neg64;
  logic [31:0] rem_neg;

  assign accept    = md_start & (state_q == MD_IDLE) & ~md_kill;
  assign op_mul    = (md_opcode == MD_MULT) | (md_opcode == MD_MULTU);
  assign op_div    = (md_opcode == MD_DIV)  | (md_opcode == MD_DIVU);
  assign op_signed = (md_opcode == MD_MULT) | (md_opcode == MD_DIV);
  assign dz_issue  = op_div & (md_op_y == 32'd0);
  assign x_mag     = op_signed ? abs32(md_op_x) : md_op_x;
  assign y_mag     = op_signed ? abs32(md_op_y) : md_op_y;

  // One 33-bit adder serves both: add multiplicand, or trial-subtract divisor.
  assign add_a     = is_div_q ? shreg_q[63:31] : {1'b0, shreg_q[63:32]};
  assign add_b     = {1'b0, opnd_q};
  assign add_res   = {1'b0, add_a} + {1'b0, add_b ^ {33{is_div_q}}} + {33'd0, is_div_q};
  assign no_borrow = add_res[33];

  always_comb begin
    iter_next = shreg_q;
    if (is_div_q) begin
      iter_next = {(no_borrow ? add_res[31:0] : shreg_q[62:31]), shreg_q[30:0], no_borrow};
    end else if (shreg_q[0]) begin
      iter_next = {add_res[32:0], shreg_q[31:1]};
    end else begin
      iter_next = {1'b0, shreg_q[63:32], shreg_q[31:1]};
    end
  end

  assign neg64   = ~shreg_q + 64'd1;
  assign rem_neg = ~shreg_q[63:32] + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (accept && (op_mul || op_div)) state_d = dz_issue ? MD_FINAL : MD_ITER;
      end
      MD_ITER: begin
        if (md_kill)              state_d = MD_IDLE;
        else if (cnt_q == 5'd0)   state_d = MD_FINAL;
      end
      MD_FINAL: state_d = MD_IDLE;
      default:  state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 5'd0;
      shreg_q   <= 64'd0;
      opnd_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            if (md_opcode == MD_MTHI) begin
              hi_q <= md_op_x;
              dz_q <= 1'b0;
            end else if (md_opcode == MD_MTLO) begin
              lo_q <= md_op_x;
              dz_q <= 1'b0;
            end else if (op_mul || op_div) begin
              dz_q      <= dz_issue;
              is_div_q  <= op_div;
              neg_res_q <= op_signed & (md_op_x[31] ^ md_op_y[31]);
              neg_rem_q <= op_signed & md_op_x[31];
              cnt_q     <= MD_LAST_CNT;
              // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
              opnd_q    <= op_mul ? x_mag : y_mag;
              if (dz_issue)    shreg_q <= {md_op_x, 32'hFFFF_FFFF};
              else if (op_mul) shreg_q <= {32'd0, y_mag};
              else             shreg_q <= {32'd0, x_mag};
            end
          end
        end
        MD_ITER: begin
          if (!md_kill) begin
            shreg_q <= iter_next;
            cnt_q   <= cnt_q - 5'd1;
          end
        end
        MD_FINAL: begin
          if (!md_kill) begin
            done_q <= 1'b1;
            if (dz_q) begin
              hi_q <= shreg_q[63:32];
              lo_q <= shreg_q[31:0];
            end else if (is_div_q) begin
              lo_q <= neg_res_q ? neg64[31:0] : shreg_q[31:0];
              hi_q <= neg_rem_q ? rem_neg : shreg_q[63:32];
            end else begin
              {hi_q, lo_q} <= neg_res_q ? neg64 : shreg_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign md_busy     = (state_q != MD_IDLE);
  assign md_done     = done_q;
  assign md_div_zero = dz_q;
  assign md_hi       = hi_q;
  assign md_lo       = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Scoreboarded bench for mult_div: arithmetic reference model, directed timing cases, random ops.
module tb_mult_div;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start, md_kill, md_busy, md_done, md_div_zero;
  logic [2:0]  md_opcode;
  logic [31:0] md_op_x, md_op_y, md_hi, md_lo;

  always #5 clk = ~clk;

  mult_div dut (
    .clk(clk), .rst(rst), .md_start(md_start), .md_opcode(md_opcode),
    .md_op_x(md_op_x), .md_op_y(md_op_y), .md_kill(md_kill),
    .md_busy(md_busy), .md_done(md_done), .md_div_zero(md_div_zero),
    .md_hi(md_hi), .md_lo(md_lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic, MIPS semantics (truncating divide, remainder follows dividend).
  task automatic ref_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] hi, output logic [31:0] lo);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      MD_MULT:  begin p = 64'(sx * sy); hi = p[63:32]; lo = p[31:0]; end
      MD_MULTU: begin p = {32'd0, x} * {32'd0, y}; hi = p[63:32]; lo = p[31:0]; end
      MD_DIV: begin
        if (y == 32'd0) begin hi = x; lo = 32'hFFFF_FFFF; end
        else begin q = sx / sy; r = sx % sy; lo = q[31:0]; hi = r[31:0]; end
      end
      MD_DIVU: begin
        if (y == 32'd0) begin hi = x; lo = 32'hFFFF_FFFF; end
        else begin lo = x / y; hi = x % y; end
      end
      default: ;
    endcase
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && md_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", md_hi, md_lo);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_hi", {32'd0, md_hi}, {32'd0, e.hi});
        check("sb_lo", {32'd0, md_lo}, {32'd0, e.lo});
        check("sb_div_zero", {63'd0, md_div_zero}, {63'd0, e.dz});
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (md_busy === 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("wait_idle_timeout", {63'd0, md_busy}, 64'd0);
  endtask

  task automatic wait_done();
    int k = 0;
    @(negedge clk);
    while (md_done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("wait_done_timeout", {63'd0, md_done}, 64'd1);
  endtask

  // Issues one op from a negedge with busy low; returns #1 after the accept edge (cycle 1).
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input bit track);
    logic [31:0] h, l;
    exp_t e;
    wait_idle();
    md_start = 1'b1; md_opcode = op; md_op_x = x; md_op_y = y;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    if (!track) return;
    case (op)
      MD_MTHI: begin model_hi = x; check("mthi_value", {32'd0, md_hi}, {32'd0, x}); end
      MD_MTLO: begin model_lo = x; check("mtlo_value", {32'd0, md_lo}, {32'd0, x}); end
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
        ref_model(op, x, y, h, l);
        e.hi = h; e.lo = l;
        e.dz = (op == MD_DIV || op == MD_DIVU) && (y == 32'd0);
        sb_q.push_back(e);
        model_hi = h; model_lo = l;
      end
      default: ;
    endcase
    if (op == MD_MTHI || op == MD_MTLO) check("mt_busy", {63'd0, md_busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev_hi, prev_lo;
    int          dones;

    rst = 1'b1; md_start = 1'b0; md_kill = 1'b0; md_opcode = 3'd0; md_op_x = 32'd0; md_op_y = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, md_busy}, 64'd0);
    check("reset_done", {63'd0, md_done}, 64'd0);
    check("reset_dz", {63'd0, md_div_zero}, 64'd0);
    check("reset_hilo", {md_hi, md_lo}, 64'd0);
    rst = 1'b0;

    // Timing of a full signed multiply.
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      check($sformatf("mult_busy_c%0d", c), {63'd0, md_busy}, {63'd0, (c <= 33)});
      check($sformatf("mult_done_c%0d", c), {63'd0, md_done}, {63'd0, (c == 34)});
      if (c == 34) check("mult_result", {md_hi, md_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    end

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_done(); check("multu_max", {md_hi, md_lo}, 64'hFFFF_FFFE_0000_0001);
    issue(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1);
    wait_done(); check("mult_minmin", {md_hi, md_lo}, 64'h4000_0000_0000_0000);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1);
    wait_done(); check("div_neg7_2", {md_hi, md_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(MD_DIVU, 32'd100, 32'd7, 1);
    wait_done(); check("divu_100_7", {md_hi, md_lo}, 64'h0000_0002_0000_000E);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done(); check("div_overflow", {md_hi, md_lo}, 64'h0000_0000_8000_0000);

    // Divide by zero shortcut, then a multiply clears the flag.
    issue(MD_DIVU, 32'h1234, 32'd0, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("dz_busy_c%0d", c), {63'd0, md_busy}, {63'd0, (c == 1)});
      check($sformatf("dz_done_c%0d", c), {63'd0, md_done}, {63'd0, (c == 2)});
      if (c == 2) begin
        check("dz_flag", {63'd0, md_div_zero}, 64'd1);
        check("dz_result", {md_hi, md_lo}, 64'h0000_1234_FFFF_FFFF);
      end
    end
    issue(MD_MULT, 32'd5, 32'd6, 1);
    check("dz_cleared", {63'd0, md_div_zero}, 64'd0);

    // MTLO, then a start during busy must be ignored.
    issue(MD_MTLO, 32'hA5A5_A5A5, 32'd0, 1);
    prev_hi = md_hi;
    issue(MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    repeat (4) @(negedge clk);
    md_start = 1'b1; md_opcode = MD_MTHI; md_op_x = 32'd1;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    check("busy_start_hi_hold", {32'd0, md_hi}, {32'd0, prev_hi});
    wait_done();
    check("busy_start_hi_final", {32'd0, md_hi}, {32'd0, model_hi});

    // Kill in IDLE blocks acceptance.
    wait_idle();
    prev_lo = md_lo;
    md_start = 1'b1; md_kill = 1'b1; md_opcode = MD_MTLO; md_op_x = 32'h55;
    @(posedge clk);
    #1;
    md_start = 1'b0; md_kill = 1'b0;
    check("kill_idle_lo", {32'd0, md_lo}, {32'd0, prev_lo});

    // Kill mid-multiply.
    prev_hi = md_hi; prev_lo = md_lo;
    issue(MD_MULT, 32'd1000, 32'd1000, 0);
    repeat (9) @(negedge clk);
    md_kill = 1'b1;
    @(posedge clk);
    #1;
    md_kill = 1'b0;
    check("kill_busy", {63'd0, md_busy}, 64'd0);
    check("kill_hilo", {md_hi, md_lo}, {prev_hi, prev_lo});
    dones = 0;
    repeat (40) begin @(negedge clk); if (md_done === 1'b1) dones++; end
    check("kill_no_done", 64'(dones), 64'd0);
    check("kill_hilo_later", {md_hi, md_lo}, {prev_hi, prev_lo});

    // Reset mid-multiply.
    issue(MD_MULT, 32'd77, 32'd99, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_hi = 32'd0; model_lo = 32'd0;
    check("rst_busy", {63'd0, md_busy}, 64'd0);
    check("rst_done", {63'd0, md_done}, 64'd0);
    check("rst_dz", {63'd0, md_div_zero}, 64'd0);
    check("rst_hilo", {md_hi, md_lo}, 64'd0);

    // Random mix.
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 5));
      issue(op, pick(), pick(), 1);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("final_hilo", {md_hi, md_lo}, {model_hi, model_lo});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
